// File: rtl/wb_arbiter.sv
// wb_arbiter
//
// Write-back arbiter in front of a dual-write-port register file. Each cycle
// it merges up to two single-cycle lane results and buffered long-latency
// results onto the two register-file write ports. Lane results always win a
// port. Long-latency results wait in a small FIFO and drain, oldest first,
// into whichever ports the lanes leave free. A 32-bit scoreboard flags
// registers that still have a long-latency write outstanding.
//
// Ports
//   clk, arst_n                    clock, asynchronous active-low reset
//   l0_valid/l0_rd/l0_data         lane-0 result (older instruction)
//   l1_valid/l1_rd/l1_data         lane-1 result (younger instruction)
//   lu_issue/lu_issue_rd           long-latency op issued, destination reg
//   lu_valid/lu_rd/lu_data/lu_ready long-latency result handshake
//   reg_write_1/waddr_1/wdata_1    register file write port 1 (registered)
//   reg_write_2/waddr_2/wdata_2    register file write port 2 (registered)
//   busy                           per-register outstanding long-latency write
//   fifo_count                     long-latency FIFO occupancy
//
// Handshake: a long-latency result transfers on any cycle where
// lu_valid && lu_ready. lu_ready depends only on the registered FIFO count,
// never on same-cycle pops. A transfer with lu_rd == 0 is accepted and
// dropped. A pushed entry becomes drainable on the following cycle.

module wb_arbiter #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            arst_n,
  input  logic                            l0_valid,
  input  logic [4:0]                      l0_rd,
  input  logic [DATA_W-1:0]               l0_data,
  input  logic                            l1_valid,
  input  logic [4:0]                      l1_rd,
  input  logic [DATA_W-1:0]               l1_data,
  input  logic                            lu_issue,
  input  logic [4:0]                      lu_issue_rd,
  input  logic                            lu_valid,
  input  logic [4:0]                      lu_rd,
  input  logic [DATA_W-1:0]               lu_data,
  output logic                            lu_ready,
  output logic                            reg_write_1,
  output logic [4:0]                      waddr_1,
  output logic [DATA_W-1:0]               wdata_1,
  output logic                            reg_write_2,
  output logic [4:0]                      waddr_2,
  output logic [DATA_W-1:0]               wdata_2,
  output logic [31:0]                     busy,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // FIFO storage and pointers
  logic [4:0]        fifo_rd_q   [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  second_idx;

  // Registered write ports
  logic              w1_q, w1_d, w2_q, w2_d;
  logic [4:0]        a1_q, a1_d, a2_q, a2_d;
  logic [DATA_W-1:0] d1_q, d1_d, d2_q, d2_d;

  // Scoreboard
  logic [31:0]       busy_q, busy_d;
  logic [31:0]       busy_set, busy_clr;

  logic              l0_cand, l1_cand;
  logic              push;
  logic [1:0]        pop_cnt;

  // When both lanes target the same register, the younger result (l1)
  // must be the one that lands, so l0 is dropped rather than ordered first.
  assign l1_cand    = l1_valid && (l1_rd != 5'd0);
  assign l0_cand    = l0_valid && (l0_rd != 5'd0) && !(l1_cand && (l0_rd == l1_rd));

  assign lu_ready   = (count_q != CNT_W'(FIFO_DEPTH));
  assign push       = lu_valid && lu_ready && (lu_rd != 5'd0);
  assign second_idx = rd_ptr_q + PTR_W'(1);

  // Port assignment. Pops are capped by the registered count, which also
  // keeps an entry pushed this cycle from being drained this cycle.
  always_comb begin
    w1_d     = 1'b0;
    a1_d     = 5'd0;
    d1_d     = '0;
    w2_d     = 1'b0;
    a2_d     = 5'd0;
    d2_d     = '0;
    pop_cnt  = 2'd0;
    busy_clr = '0;
    if (l0_cand && l1_cand) begin
      w1_d = 1'b1; a1_d = l0_rd; d1_d = l0_data;
      w2_d = 1'b1; a2_d = l1_rd; d2_d = l1_data;
    end else if (l0_cand || l1_cand) begin
      w1_d = 1'b1;
      a1_d = l0_cand ? l0_rd   : l1_rd;
      d1_d = l0_cand ? l0_data : l1_data;
      if (count_q != '0) begin
        w2_d    = 1'b1;
        a2_d    = fifo_rd_q[rd_ptr_q];
        d2_d    = fifo_data_q[rd_ptr_q];
        pop_cnt = 2'd1;
        busy_clr[fifo_rd_q[rd_ptr_q]] = 1'b1;
      end
    end else begin
      if (count_q != '0) begin
        w1_d    = 1'b1;
        a1_d    = fifo_rd_q[rd_ptr_q];
        d1_d    = fifo_data_q[rd_ptr_q];
        pop_cnt = 2'd1;
        busy_clr[fifo_rd_q[rd_ptr_q]] = 1'b1;
      end
      if (count_q >= CNT_W'(2)) begin
        w2_d    = 1'b1;
        a2_d    = fifo_rd_q[second_idx];
        d2_d    = fifo_data_q[second_idx];
        pop_cnt = 2'd2;
        busy_clr[fifo_rd_q[second_idx]] = 1'b1;
      end
    end
  end

  // Pointer and count update; pointers wrap naturally (power-of-two depth).
  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_cnt);
    wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop_cnt);
  end

  // Scoreboard: a set in the same cycle as a clear of the same bit wins,
  // because the new issue represents a fresh outstanding write.
  always_comb begin
    busy_set = '0;
    if (lu_issue && (lu_issue_rd != 5'd0)) busy_set[lu_issue_rd] = 1'b1;
    busy_d    = (busy_q & ~busy_clr) | busy_set;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
      w1_q     <= 1'b0;
      a1_q     <= 5'd0;
      d1_q     <= '0;
      w2_q     <= 1'b0;
      a2_q     <= 5'd0;
      d2_q     <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      w1_q     <= w1_d;
      a1_q     <= a1_d;
      d1_q     <= d1_d;
      w2_q     <= w2_d;
      a2_q     <= a2_d;
      d2_q     <= d2_d;
    end
  end

  // Storage needs no reset: entries are only read while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= lu_rd;
      fifo_data_q[wr_ptr_q] <= lu_data;
    end
  end

  assign reg_write_1 = w1_q;
  assign waddr_1     = a1_q;
  assign wdata_1     = d1_q;
  assign reg_write_2 = w2_q;
  assign waddr_2     = a2_q;
  assign wdata_2     = d2_q;
  assign busy        = busy_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter: expected write-port words are queued as
// stimulus is driven and compared one cycle later; occupancy, ready and
// scoreboard values are compared directly against hand-derived constants.

module tb_wb_arbiter;

  localparam int DW = 16;
  localparam int W  = 1 + 5 + DW + 1 + 5 + DW;

  // clock / reset
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  logic          l0_valid, l1_valid, lu_issue, lu_valid, lu_ready;
  logic [4:0]    l0_rd, l1_rd, lu_issue_rd, lu_rd, waddr_1, waddr_2;
  logic [DW-1:0] l0_data, l1_data, lu_data, wdata_1, wdata_2;
  logic          reg_write_1, reg_write_2;
  logic [31:0]   busy;
  logic [2:0]    fifo_count;

  wb_arbiter #(.DATA_W(DW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .arst_n(arst_n),
    .l0_valid(l0_valid), .l0_rd(l0_rd), .l0_data(l0_data),
    .l1_valid(l1_valid), .l1_rd(l1_rd), .l1_data(l1_data),
    .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .reg_write_1(reg_write_1), .waddr_1(waddr_1), .wdata_1(wdata_1),
    .reg_write_2(reg_write_2), .waddr_2(waddr_2), .wdata_2(wdata_2),
    .busy(busy), .fifo_count(fifo_count)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [W-1:0] pk(input logic w1, input logic [4:0] a1, input logic [DW-1:0] d1,
                                      input logic w2, input logic [4:0] a2, input logic [DW-1:0] d2);
    return {w1, a1, d1, w2, a2, d2};
  endfunction

  function automatic logic [W-1:0] ports_now();
    return {reg_write_1, waddr_1, wdata_1, reg_write_2, waddr_2, wdata_2};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_lanes(input logic v0, input logic [4:0] r0, input logic [DW-1:0] d0,
                           input logic v1, input logic [4:0] r1, input logic [DW-1:0] d1);
    l0_valid = v0; l0_rd = r0; l0_data = d0;
    l1_valid = v1; l1_rd = r1; l1_data = d1;
  endtask

  task automatic set_lu(input logic v, input logic [4:0] r, input logic [DW-1:0] d);
    lu_valid = v; lu_rd = r; lu_data = d;
  endtask

  task automatic set_iss(input logic v, input logic [4:0] r);
    lu_issue = v; lu_issue_rd = r;
  endtask

  task automatic idle();
    set_lanes(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    set_lu(1'b0, 5'd0, '0);
    set_iss(1'b0, 5'd0);
  endtask

  // Queue the expected port word for the inputs now applied, advance one
  // edge and compare against what the DUT presents.
  task automatic cyc(input string tag, input logic [W-1:0] e);
    logic [W-1:0] x;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      x = exp_q.pop_front();
      chk(tag, 64'(ports_now()), 64'(x));
    end
  endtask

  initial begin
    idle();
    // reset held
    #12;
    chk("rst_ports", 64'(ports_now()), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_count", 64'(fifo_count), 64'(0));
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", 64'(lu_ready), 64'(1));

    // both lanes
    set_lanes(1'b1, 5'd3, 16'h1111, 1'b1, 5'd5, 16'h2222);
    cyc("both_lanes", pk(1'b1, 5'd3, 16'h1111, 1'b1, 5'd5, 16'h2222));

    // lane clash: younger wins on port 1
    set_lanes(1'b1, 5'd7, 16'hAAAA, 1'b1, 5'd7, 16'hBBBB);
    cyc("lane_clash", pk(1'b1, 5'd7, 16'hBBBB, 1'b0, 5'd0, 16'h0));

    // x0 write suppressed
    set_lanes(1'b1, 5'd0, 16'h1234, 1'b0, 5'd0, 16'h0);
    cyc("x0_write", pk(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0));

    // fill FIFO with rd 8..11 while both lanes occupy the ports
    for (int i = 0; i < 4; i++) begin
      set_lanes(1'b1, 5'(20 + i), 16'(16'hC000 + i), 1'b1, 5'(24 + i), 16'(16'hD000 + i));
      set_lu(1'b1, 5'(8 + i), 16'(16'h8008 + i));
      cyc("fill_ports", pk(1'b1, 5'(20 + i), 16'(16'hC000 + i), 1'b1, 5'(24 + i), 16'(16'hD000 + i)));
      chk("fill_count", 64'(fifo_count), 64'(i + 1));
    end
    chk("full_ready", 64'(lu_ready), 64'(0));

    // offered while full: not accepted
    set_lanes(1'b1, 5'd28, 16'hC004, 1'b1, 5'd29, 16'hD004);
    set_lu(1'b1, 5'd13, 16'h800D);
    cyc("full_ports", pk(1'b1, 5'd28, 16'hC004, 1'b1, 5'd29, 16'hD004));
    chk("full_count", 64'(fifo_count), 64'(4));

    // lanes idle: drain two
    idle();
    cyc("drain_two", pk(1'b1, 5'd8, 16'h8008, 1'b1, 5'd9, 16'h8009));
    chk("drain_count", 64'(fifo_count), 64'(2));
    chk("drain_ready", 64'(lu_ready), 64'(1));

    // single free slot, l0 only
    set_lanes(1'b1, 5'd1, 16'h0101, 1'b0, 5'd0, 16'h0);
    cyc("slot_l0", pk(1'b1, 5'd1, 16'h0101, 1'b1, 5'd10, 16'h800A));
    chk("slot_l0_count", 64'(fifo_count), 64'(1));

    // single free slot, l1 only
    set_lanes(1'b0, 5'd0, 16'h0, 1'b1, 5'd30, 16'h3030);
    cyc("slot_l1", pk(1'b1, 5'd30, 16'h3030, 1'b1, 5'd11, 16'h800B));
    chk("slot_l1_count", 64'(fifo_count), 64'(0));

    idle();
    cyc("empty_idle", pk(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0));

    // scoreboard set / clear
    set_iss(1'b1, 5'd6);
    cyc("sb_issue", pk(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0));
    chk("sb_set", 64'(busy), 64'(32'h0000_0040));
    idle();
    set_lu(1'b1, 5'd6, 16'h6666);
    cyc("sb_push_nodrain", pk(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0));
    chk("sb_push_count", 64'(fifo_count), 64'(1));
    chk("sb_held", 64'(busy), 64'(32'h0000_0040));
    idle();
    cyc("sb_drain", pk(1'b1, 5'd6, 16'h6666, 1'b0, 5'd0, 16'h0));
    chk("sb_clear", 64'(busy), 64'(0));

    // set and clear of bit 6 in one cycle
    set_iss(1'b1, 5'd6);
    cyc("sb2_issue", pk(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0));
    idle();
    set_lu(1'b1, 5'd6, 16'h6767);
    cyc("sb2_push", pk(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0));
    idle();
    set_iss(1'b1, 5'd6);
    cyc("sb2_drain", pk(1'b1, 5'd6, 16'h6767, 1'b0, 5'd0, 16'h0));
    chk("sb_set_wins", 64'(busy), 64'(32'h0000_0040));

    // issue to x0 leaves busy[0] clear
    set_iss(1'b1, 5'd0);
    cyc("sb_x0", pk(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0));
    chk("sb_x0_busy", 64'(busy), 64'(32'h0000_0040));

    // reset mid-operation
    for (int i = 0; i < 3; i++) begin
      set_lanes(1'b1, 5'(17 + i), 16'(16'hE000 + i), 1'b1, 5'(21 + i), 16'(16'hF000 + i));
      set_lu(1'b1, 5'(14 + i), 16'(16'h900E + i));
      set_iss(i == 0, 5'd14);
      cyc("pre_rst", pk(1'b1, 5'(17 + i), 16'(16'hE000 + i), 1'b1, 5'(21 + i), 16'(16'hF000 + i)));
    end
    chk("pre_rst_count", 64'(fifo_count), 64'(3));
    chk("pre_rst_busy", 64'(busy), 64'(32'h0000_4040));
    arst_n = 1'b0;
    #1;
    chk("mid_rst_ports", 64'(ports_now()), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_count", 64'(fifo_count), 64'(0));
    idle();
    #2;
    arst_n = 1'b1;
    set_lanes(1'b1, 5'd2, 16'h2020, 1'b0, 5'd0, 16'h0);
    cyc("post_rst_lane", pk(1'b1, 5'd2, 16'h2020, 1'b0, 5'd0, 16'h0));
    idle();
    cyc("post_rst_idle", pk(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0));
    chk("post_rst_count", 64'(fifo_count), 64'(0));
    chk("post_rst_ready", 64'(lu_ready), 64'(1));

    // final report
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL leftover_queue observed=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
